// File: rtl/mem_wb_stage_pkg.sv
// Shared constants and pipeline-control helpers for the MEM/WB stage.
// The stall-index constants are used where the controller's stall vector is sliced.
package mem_wb_stage_pkg;

    localparam logic RST_ENABLE    = 1'b1;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam int   NOP_REG_ADDR  = 0;
    localparam int   ZERO_WORD     = 0;
    localparam int   STALL_MEM_IDX = 4;
    localparam int   STALL_WB_IDX  = 5;

    typedef enum logic [2:0] {
        ACT_RESET,
        ACT_FLUSH,
        ACT_BUBBLE,
        ACT_HOLD,
        ACT_LOAD
    } pipe_act_e;

    // Resolves the per-edge action; earlier checks win over later ones.
    function automatic pipe_act_e pipe_action(
        input logic rst,
        input logic flush,
        input logic stall_mem,
        input logic stall_wb
    );
        if (rst == RST_ENABLE) return ACT_RESET;
        if (flush)             return ACT_FLUSH;
        if (stall_wb)          return ACT_HOLD;
        if (stall_mem)         return ACT_BUBBLE;
        return ACT_LOAD;
    endfunction

endpackage

// File: rtl/mem_wb_stage_pipe_reg_ctl.sv
// Generic pipeline register with reset, clear-to-bubble and hold.
// rst and clear both load rst_val; hold keeps q; otherwise q follows d.
module pipe_reg_ctl
    import mem_wb_stage_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         hold,
    input  logic         clear,
    input  logic [W-1:0] d,
    input  logic [W-1:0] rst_val,
    output logic [W-1:0] q
);

    logic [W-1:0] q_d;
    logic [W-1:0] q_q;

    always_comb begin
        q_d = q_q;
        if (clear) begin
            q_d = rst_val;
        end else if (!hold) begin
            q_d = d;
        end
    end

    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            q_q <= rst_val;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: NUM_WP GPR write lanes, HI/LO, LLbit and valid,
// with stall hold, MEM-only-stall bubble, flush, and a retired-instruction counter.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_WP = 1,
    parameter int CNT_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall_mem,
    input  logic                     stall_wb,
    input  logic                     flush,
    input  logic                     mem_valid,
    input  logic [NUM_WP*ADDR_W-1:0] mem_wd,
    input  logic [NUM_WP-1:0]        mem_wreg,
    input  logic [NUM_WP*DATA_W-1:0] mem_wdata,
    input  logic                     mem_whilo,
    input  logic [DATA_W-1:0]        mem_hi,
    input  logic [DATA_W-1:0]        mem_lo,
    input  logic                     mem_llbit_we,
    input  logic                     mem_llbit_value,
    output logic                     wb_valid,
    output logic [NUM_WP*ADDR_W-1:0] wb_wd,
    output logic [NUM_WP-1:0]        wb_wreg,
    output logic [NUM_WP*DATA_W-1:0] wb_wdata,
    output logic                     wb_whilo,
    output logic [DATA_W-1:0]        wb_hi,
    output logic [DATA_W-1:0]        wb_lo,
    output logic                     wb_llbit_we,
    output logic                     wb_llbit_value,
    output logic [CNT_W-1:0]         retire_cnt
);

    localparam int LANE_W = NUM_WP * (ADDR_W + 1 + DATA_W);
    localparam int HILO_W = 2 * DATA_W + 1;

    pipe_act_e act;
    logic      hold;
    logic      clear;

    assign act   = pipe_action(rst, flush, stall_mem, stall_wb);
    assign hold  = (act == ACT_HOLD);
    assign clear = (act == ACT_FLUSH) || (act == ACT_BUBBLE);

    // An invalid instruction still carries address/data but must not write.
    logic [NUM_WP-1:0] wreg_gated;
    logic              whilo_gated;
    logic              llbit_we_gated;

    assign wreg_gated     = mem_wreg & {NUM_WP{mem_valid}};
    assign whilo_gated    = mem_whilo & mem_valid;
    assign llbit_we_gated = mem_llbit_we & mem_valid;

    logic [LANE_W-1:0] lane_d;
    logic [LANE_W-1:0] lane_rst;
    logic [LANE_W-1:0] lane_q;

    assign lane_d   = {mem_wd, wreg_gated, mem_wdata};
    assign lane_rst = {{NUM_WP{ADDR_W'(NOP_REG_ADDR)}},
                       {NUM_WP{WRITE_DISABLE}},
                       {NUM_WP{DATA_W'(ZERO_WORD)}}};
    assign {wb_wd, wb_wreg, wb_wdata} = lane_q;

    pipe_reg_ctl #(.W(LANE_W)) u_lanes (
        .clk     (clk),
        .rst     (rst),
        .hold    (hold),
        .clear   (clear),
        .d       (lane_d),
        .rst_val (lane_rst),
        .q       (lane_q)
    );

    logic [HILO_W-1:0] hilo_q;

    assign {wb_whilo, wb_hi, wb_lo} = hilo_q;

    pipe_reg_ctl #(.W(HILO_W)) u_hilo (
        .clk     (clk),
        .rst     (rst),
        .hold    (hold),
        .clear   (clear),
        .d       ({whilo_gated, mem_hi, mem_lo}),
        .rst_val ({WRITE_DISABLE, DATA_W'(ZERO_WORD), DATA_W'(ZERO_WORD)}),
        .q       (hilo_q)
    );

    logic [1:0] llbit_q;

    assign {wb_llbit_we, wb_llbit_value} = llbit_q;

    pipe_reg_ctl #(.W(2)) u_llbit (
        .clk     (clk),
        .rst     (rst),
        .hold    (hold),
        .clear   (clear),
        .d       ({llbit_we_gated, mem_llbit_value}),
        .rst_val ({WRITE_DISABLE, 1'b0}),
        .q       (llbit_q)
    );

    pipe_reg_ctl #(.W(1)) u_valid (
        .clk     (clk),
        .rst     (rst),
        .hold    (hold),
        .clear   (clear),
        .d       (mem_valid),
        .rst_val (1'b0),
        .q       (wb_valid)
    );

    logic [CNT_W-1:0] retire_cnt_d;
    logic [CNT_W-1:0] retire_cnt_q;

    // Wraps silently at 2^CNT_W.
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if ((act == ACT_LOAD) && mem_valid) begin
            retire_cnt_d = retire_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage (NUM_WP=2, CNT_W=4): directed steps
// followed by randomized cycles, all compared against a behavioural model.
module tb_mem_wb_stage;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NW = 2;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            stall_mem;
    logic            stall_wb;
    logic            flush;
    logic            mem_valid;
    logic [NW*AW-1:0] mem_wd;
    logic [NW-1:0]    mem_wreg;
    logic [NW*DW-1:0] mem_wdata;
    logic            mem_whilo;
    logic [DW-1:0]   mem_hi;
    logic [DW-1:0]   mem_lo;
    logic            mem_llbit_we;
    logic            mem_llbit_value;
    logic            wb_valid;
    logic [NW*AW-1:0] wb_wd;
    logic [NW-1:0]    wb_wreg;
    logic [NW*DW-1:0] wb_wdata;
    logic            wb_whilo;
    logic [DW-1:0]   wb_hi;
    logic [DW-1:0]   wb_lo;
    logic            wb_llbit_we;
    logic            wb_llbit_value;
    logic [CW-1:0]   retire_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.DATA_W(DW), .ADDR_W(AW), .NUM_WP(NW), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_mem       (stall_mem),
        .stall_wb        (stall_wb),
        .flush           (flush),
        .mem_valid       (mem_valid),
        .mem_wd          (mem_wd),
        .mem_wreg        (mem_wreg),
        .mem_wdata       (mem_wdata),
        .mem_whilo       (mem_whilo),
        .mem_hi          (mem_hi),
        .mem_lo          (mem_lo),
        .mem_llbit_we    (mem_llbit_we),
        .mem_llbit_value (mem_llbit_value),
        .wb_valid        (wb_valid),
        .wb_wd           (wb_wd),
        .wb_wreg         (wb_wreg),
        .wb_wdata        (wb_wdata),
        .wb_whilo        (wb_whilo),
        .wb_hi           (wb_hi),
        .wb_lo           (wb_lo),
        .wb_llbit_we     (wb_llbit_we),
        .wb_llbit_value  (wb_llbit_value),
        .retire_cnt      (retire_cnt)
    );

    // Reference model of what WB should hold after the next edge.
    logic          m_valid;
    logic [AW-1:0] m_wd    [NW];
    logic          m_wreg  [NW];
    logic [DW-1:0] m_wdata [NW];
    logic          m_whilo;
    logic [DW-1:0] m_hi;
    logic [DW-1:0] m_lo;
    logic          m_llwe;
    logic          m_llval;
    int            m_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_bubble();
        m_valid = 1'b0;
        for (int i = 0; i < NW; i++) begin
            m_wd[i]    = '0;
            m_wreg[i]  = 1'b0;
            m_wdata[i] = '0;
        end
        m_whilo = 1'b0;
        m_hi    = '0;
        m_lo    = '0;
        m_llwe  = 1'b0;
        m_llval = 1'b0;
    endtask

    task automatic model_step();
        if (rst) begin
            model_bubble();
            m_cnt = 0;
        end else if (flush) begin
            model_bubble();
        end else if (!stall_wb) begin
            if (stall_mem) begin
                model_bubble();
            end else begin
                m_valid = mem_valid;
                for (int i = 0; i < NW; i++) begin
                    m_wd[i]    = mem_wd[i*AW +: AW];
                    m_wreg[i]  = mem_wreg[i] & mem_valid;
                    m_wdata[i] = mem_wdata[i*DW +: DW];
                end
                m_whilo = mem_whilo & mem_valid;
                m_hi    = mem_hi;
                m_lo    = mem_lo;
                m_llwe  = mem_llbit_we & mem_valid;
                m_llval = mem_llbit_value;
                if (mem_valid) m_cnt = (m_cnt + 1) % (1 << CW);
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 64'(wb_valid), 64'(m_valid));
        for (int i = 0; i < NW; i++) begin
            chk($sformatf("%s.wd%0d", tag, i),    64'(wb_wd[i*AW +: AW]),    64'(m_wd[i]));
            chk($sformatf("%s.wreg%0d", tag, i),  64'(wb_wreg[i]),           64'(m_wreg[i]));
            chk($sformatf("%s.wdata%0d", tag, i), 64'(wb_wdata[i*DW +: DW]), 64'(m_wdata[i]));
        end
        chk({tag, ".whilo"}, 64'(wb_whilo),       64'(m_whilo));
        chk({tag, ".hi"},    64'(wb_hi),          64'(m_hi));
        chk({tag, ".lo"},    64'(wb_lo),          64'(m_lo));
        chk({tag, ".llwe"},  64'(wb_llbit_we),    64'(m_llwe));
        chk({tag, ".llval"}, 64'(wb_llbit_value), 64'(m_llval));
        chk({tag, ".cnt"},   64'(retire_cnt),     64'(m_cnt));
    endtask

    // Inputs are stable here; the model sees what the DUT samples at the edge.
    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        rst = 1'b0; stall_mem = 1'b0; stall_wb = 1'b0; flush = 1'b0;
        mem_valid = 1'b0; mem_wd = '0; mem_wreg = '0; mem_wdata = '0;
        mem_whilo = 1'b0; mem_hi = '0; mem_lo = '0;
        mem_llbit_we = 1'b0; mem_llbit_value = 1'b0;
    endtask

    task automatic random_payload();
        mem_valid       = 1'($urandom_range(0, 1));
        mem_wd          = (NW*AW)'($urandom);
        mem_wreg        = NW'($urandom);
        mem_wdata       = {$urandom, $urandom};
        mem_whilo       = 1'($urandom_range(0, 1));
        mem_hi          = $urandom;
        mem_lo          = $urandom;
        mem_llbit_we    = 1'($urandom_range(0, 1));
        mem_llbit_value = 1'($urandom_range(0, 1));
    endtask

    initial begin
        idle_inputs();
        model_bubble();
        m_cnt = 0;

        // Reset with live MEM traffic.
        rst = 1'b1; mem_valid = 1'b1; mem_wreg = 2'b11;
        mem_wdata = {32'hDEADBEEF, 32'hDEADBEEF};
        tick("reset0");
        tick("reset1");
        chk("reset_cnt", 64'(retire_cnt), 64'd0);

        // Dual-lane pass-through.
        idle_inputs();
        mem_valid = 1'b1; mem_wreg = 2'b11;
        mem_wd    = {5'd7, 5'd3};
        mem_wdata = {32'h22222222, 32'h11111111};
        tick("pass");
        chk("pass_wd0",   64'(wb_wd[4:0]),    64'd3);
        chk("pass_wd1",   64'(wb_wd[9:5]),    64'd7);
        chk("pass_data1", 64'(wb_wdata[63:32]), 64'h22222222);
        chk("pass_cnt",   64'(retire_cnt),    64'd1);

        for (int i = 0; i < 10; i++) begin
            random_payload();
            mem_valid = 1'b1;
            tick("b2b");
        end
        chk("b2b_cnt", 64'(retire_cnt), 64'd11);

        // MEM-only stall inserts a bubble.
        idle_inputs();
        stall_mem = 1'b1; mem_valid = 1'b1; mem_wreg = 2'b01; mem_wd = {5'd0, 5'd5};
        mem_wdata = {32'h0, 32'h55555555};
        tick("bubble");
        chk("bubble_wreg", 64'(wb_wreg),    64'd0);
        chk("bubble_wd",   64'(wb_wd),      64'd0);
        chk("bubble_cnt",  64'(retire_cnt), 64'd11);

        // WB stall holds r9 while MEM changes underneath.
        idle_inputs();
        mem_valid = 1'b1; mem_wreg = 2'b01; mem_wd = {5'd0, 5'd9};
        mem_wdata = {32'h0, 32'hA5A5A5A5};
        tick("hold_load");
        stall_wb = 1'b1; mem_wd = {5'd4, 5'd4}; mem_wdata = {32'h4, 32'h4};
        for (int i = 0; i < 3; i++) begin
            stall_mem = ~stall_mem;
            tick("hold");
            chk("hold_wd",   64'(wb_wd[4:0]),     64'd9);
            chk("hold_data", 64'(wb_wdata[31:0]), 64'hA5A5A5A5);
            chk("hold_cnt",  64'(retire_cnt),     64'd12);
        end

        // Flush beats a WB stall.
        idle_inputs();
        mem_valid = 1'b1; mem_whilo = 1'b1; mem_hi = 32'h1; mem_lo = 32'h2;
        tick("hilo_load");
        stall_wb = 1'b1; flush = 1'b1;
        tick("flush");
        chk("flush_whilo", 64'(wb_whilo), 64'd0);
        chk("flush_hi",    64'(wb_hi),    64'd0);
        chk("flush_valid", 64'(wb_valid), 64'd0);

        // Enables gated by mem_valid=0.
        idle_inputs();
        mem_wreg = 2'b11; mem_whilo = 1'b1; mem_llbit_we = 1'b1; mem_wd = {5'd1, 5'd2};
        tick("gate");
        chk("gate_wreg", 64'(wb_wreg),     64'd0);
        chk("gate_llwe", 64'(wb_llbit_we), 64'd0);
        chk("gate_cnt",  64'(retire_cnt),  64'd13);

        // Counter wrap 15 -> 0.
        rst = 1'b1;
        tick("wrap_rst");
        idle_inputs();
        mem_valid = 1'b1;
        for (int i = 0; i < 15; i++) tick("wrap_fill");
        chk("wrap_15", 64'(retire_cnt), 64'd15);
        tick("wrap");
        chk("wrap_0", 64'(retire_cnt), 64'd0);

        // Randomized control and payload.
        for (int i = 0; i < 400; i++) begin
            random_payload();
            rst       = ($urandom_range(0, 49) == 0);
            flush     = ($urandom_range(0, 9) == 0);
            stall_mem = ($urandom_range(0, 3) == 0);
            stall_wb  = ($urandom_range(0, 3) == 0);
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
